ff_mode_bank: RTL and testbench

//  Parametrised bank of WIDTH flip-flop lanes, one register per lane, shared mode select.

---
 rtl/ff_mode_bank.sv | 120 ++++++++++++
 tb/tb_ff_mode_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ff_mode_bank.sv
// rtl/ff_mode_bank.sv - bank of D/T/JK/SR flip-flop lanes with shared mode, clear and flip statistics
// Each lane picks its next state from the shared mode; statistics track flips and illegal SR input.
module ff_mode_bank #(
  parameter int                WIDTH     = 8,
  parameter int                CNT_W     = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [1:0]        mode_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic              stat_clr_i,
  output logic [WIDTH-1:0]  q_o,
  output logic [WIDTH-1:0]  qn_o,
  output logic [WIDTH-1:0]  chg_o,
  output logic [WIDTH-1:0]  sr_err_o,
  output logic [CNT_W-1:0]  flip_cnt_o,
  output logic              cnt_sat_o
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  localparam int PC_W  = $clog2(WIDTH + 1);
  // Sum is one bit wider than the larger operand so overflow is always visible.
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic [WIDTH-1:0] sr_err_q, sr_err_d;
  logic [CNT_W-1:0] flip_cnt_q, flip_cnt_d;
  logic             cnt_sat_q, cnt_sat_d;

  logic [WIDTH-1:0] sr_hit;
  logic [WIDTH-1:0] flips;
  logic [PC_W-1:0]  pop;
  logic [SUM_W-1:0] sum_base;
  logic [SUM_W-1:0] sum;
  logic             ovf;

  always_comb begin
    q_d    = q_q;
    sr_hit = '0;
    if (clr_i) begin
      q_d = RESET_VAL;
    end else if (en_i) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (mode_i)
          MODE_D: q_d[i] = a_i[i];
          MODE_T: q_d[i] = a_i[i] ? ~q_q[i] : q_q[i];
          MODE_JK: begin
            case ({a_i[i], b_i[i]})
              2'b01:   q_d[i] = 1'b0;
              2'b10:   q_d[i] = 1'b1;
              2'b11:   q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          MODE_SR: begin
            case ({a_i[i], b_i[i]})
              2'b01:   q_d[i] = 1'b0;
              2'b10:   q_d[i] = 1'b1;
              2'b11:   sr_hit[i] = 1'b1;
              default: q_d[i] = q_q[i];
            endcase
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end
  end

  assign flips = q_q ^ q_d;
  assign chg_d = flips;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PC_W'(flips[i]);
    end
  end

  // stat_clr restarts the statistics from this edge's events rather than dropping them.
  assign sum_base   = stat_clr_i ? '0 : SUM_W'(flip_cnt_q);
  assign sum        = sum_base + SUM_W'(pop);
  assign ovf        = (sum > CNT_MAX);
  assign flip_cnt_d = ovf ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  assign cnt_sat_d  = (stat_clr_i ? 1'b0 : cnt_sat_q) | ovf;
  assign sr_err_d   = (stat_clr_i ? '0 : sr_err_q) | sr_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q        <= RESET_VAL;
      chg_q      <= '0;
      sr_err_q   <= '0;
      flip_cnt_q <= '0;
      cnt_sat_q  <= 1'b0;
    end else begin
      q_q        <= q_d;
      chg_q      <= chg_d;
      sr_err_q   <= sr_err_d;
      flip_cnt_q <= flip_cnt_d;
      cnt_sat_q  <= cnt_sat_d;
    end
  end

  assign q_o        = q_q;
  assign qn_o       = ~q_q;
  assign chg_o      = chg_q;
  assign sr_err_o   = sr_err_q;
  assign flip_cnt_o = flip_cnt_q;
  assign cnt_sat_o  = cnt_sat_q;

endmodule

// File: tb/tb_ff_mode_bank.sv
// tb/tb_ff_mode_bank.sv - scoreboard bench for ff_mode_bank against a lane-level reference model
module tb_ff_mode_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       en = 1'b0, clr = 1'b0, stat_clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = 8'h00, b = 8'h00;

  logic [7:0]  q, qn, chg, err;
  logic [15:0] cnt16;
  logic        sat16;
  logic [7:0]  q4, qn4, chg4, err4;
  logic [3:0]  cnt4;
  logic        sat4;

  ff_mode_bank #(.WIDTH(8), .CNT_W(16), .RESET_VAL(8'h00)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode),
    .a_i(a), .b_i(b), .stat_clr_i(stat_clr),
    .q_o(q), .qn_o(qn), .chg_o(chg), .sr_err_o(err), .flip_cnt_o(cnt16), .cnt_sat_o(sat16)
  );

  ff_mode_bank #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut_small (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode),
    .a_i(a), .b_i(b), .stat_clr_i(stat_clr),
    .q_o(q4), .qn_o(qn4), .chg_o(chg4), .sr_err_o(err4), .flip_cnt_o(cnt4), .cnt_sat_o(sat4)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] chg;
    logic [7:0] err;
    int         cnt;
    logic       sat;
    int         cnt4;
    logic       sat4;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_q = 8'h00, m_chg = 8'h00, m_err = 8'h00;
  int         m_cnt = 0, m_cnt4 = 0;
  logic       m_sat = 1'b0, m_sat4 = 1'b0;

  task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%s]: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  function automatic logic lane_next(input logic [1:0] m, input logic cur, input logic ai, input logic bi);
    if (m == 2'd0) return ai;
    if (m == 2'd1) return ai ? ~cur : cur;
    if (m == 2'd2) begin
      if (ai && bi) return ~cur;
      if (ai) return 1'b1;
      if (bi) return 1'b0;
      return cur;
    end
    if (ai && !bi) return 1'b1;
    if (bi && !ai) return 1'b0;
    return cur;
  endfunction

  function automatic int sat_add(input int base, input int inc, input int maxv, output logic ovf);
    int s;
    s = base + inc;
    ovf = (s > maxv);
    return ovf ? maxv : s;
  endfunction

  task automatic push_exp(input string tag);
    exp_t e;
    e.q = m_q; e.chg = m_chg; e.err = m_err;
    e.cnt = m_cnt; e.sat = m_sat; e.cnt4 = m_cnt4; e.sat4 = m_sat4; e.tag = tag;
    sb.push_back(e);
  endtask

  // Drives one edge's inputs, predicts the post-edge state, then waits to posedge+2.
  task automatic step(input logic [1:0] m, input logic e_in, input logic c_in, input logic sc_in,
                      input logic [7:0] av, input logic [7:0] bv, input string tag);
    logic [7:0] nq;
    logic [7:0] ill;
    int         nflip;
    logic       o16, o4;
    mode = m; en = e_in; clr = c_in; stat_clr = sc_in; a = av; b = bv;
    nq = m_q; ill = 8'h00; nflip = 0;
    if (c_in) nq = 8'h00;
    else if (e_in) begin
      for (int i = 0; i < 8; i++) begin
        nq[i] = lane_next(m, m_q[i], av[i], bv[i]);
        if (m == 2'd3 && av[i] && bv[i]) ill[i] = 1'b1;
      end
    end
    for (int i = 0; i < 8; i++) if (nq[i] != m_q[i]) nflip++;
    m_chg  = nq ^ m_q;
    m_q    = nq;
    m_err  = (sc_in ? 8'h00 : m_err) | ill;
    m_cnt  = sat_add(sc_in ? 0 : m_cnt, nflip, 65535, o16);
    m_sat  = (sc_in ? 1'b0 : m_sat) | o16;
    m_cnt4 = sat_add(sc_in ? 0 : m_cnt4, nflip, 15, o4);
    m_sat4 = (sc_in ? 1'b0 : m_sat4) | o4;
    push_exp(tag);
    @(posedge clk);
    #2;
  endtask

  // Asserts reset between edges, holds it across one edge, releases at posedge+2.
  task automatic do_reset(input string tag);
    m_q = 8'h00; m_chg = 8'h00; m_err = 8'h00;
    m_cnt = 0; m_sat = 1'b0; m_cnt4 = 0; m_sat4 = 1'b0;
    push_exp({tag, "_async"});
    rst_n = 1'b0;
    #5;
    push_exp({tag, "_held"});
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    logic [7:0] nq;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        nq = ~e.q;
        chk("q",        e.tag, 32'(q),     32'(e.q));
        chk("qn",       e.tag, 32'(qn),    32'(nq));
        chk("chg",      e.tag, 32'(chg),   32'(e.chg));
        chk("sr_err",   e.tag, 32'(err),   32'(e.err));
        chk("flip_cnt", e.tag, 32'(cnt16), 32'(e.cnt));
        chk("cnt_sat",  e.tag, 32'(sat16), 32'(e.sat));
        chk("q_w4",     e.tag, 32'(q4),    32'(e.q));
        chk("cnt_w4",   e.tag, 32'(cnt4),  32'(e.cnt4));
        chk("sat_w4",   e.tag, 32'(sat4),  32'(e.sat4));
      end
    end
  end

  initial begin
    @(posedge clk);
    #2;
    do_reset("rst0");

    // T toggling; narrow counter saturates on the second edge and holds.
    step(2'd1, 1, 0, 0, 8'hFF, 8'h00, "t1");
    step(2'd1, 1, 0, 0, 8'hFF, 8'h00, "t2");
    step(2'd1, 1, 0, 0, 8'hFF, 8'h00, "t3");

    // JK from 0xF0.
    step(2'd0, 1, 0, 1, 8'hF0, 8'h00, "load_f0");
    step(2'd2, 1, 0, 0, 8'h3C, 8'hC3, "jk1");
    step(2'd2, 1, 0, 0, 8'hFF, 8'hFF, "jk2");

    // SR illegal lanes hold and set the sticky flag; stat_clr keeps only new events.
    step(2'd0, 1, 0, 1, 8'h0F, 8'h00, "load_0f");
    step(2'd3, 1, 0, 0, 8'h81, 8'h81, "sr_ill");
    step(2'd3, 1, 0, 1, 8'h01, 8'h01, "sr_statclr");
    step(2'd3, 0, 0, 0, 8'hFF, 8'hFF, "sr_disabled");

    // clr ignores en and is counted; then idle hold.
    step(2'd0, 1, 0, 0, 8'hA5, 8'h00, "load_a5");
    step(2'd1, 0, 1, 0, 8'hFF, 8'h00, "clr");
    step(2'd1, 0, 0, 0, 8'hFF, 8'h00, "hold");
    step(2'd3, 1, 1, 0, 8'hFF, 8'hFF, "clr_beats_sr");

    // Reset in the middle of toggling.
    step(2'd1, 1, 0, 0, 8'h5A, 8'h00, "pre_rst1");
    step(2'd1, 1, 0, 0, 8'hFF, 8'h00, "pre_rst2");
    a = 8'hFF; en = 1'b1; mode = 2'd1;
    do_reset("rst_mid");
    step(2'd1, 1, 0, 0, 8'hFF, 8'h00, "post_rst");

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 40) == 0) do_reset("rnd_rst");
      else step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 7) == 0), 8'($urandom), 8'($urandom), "rnd");
    end

    @(posedge clk);
    #2;
    chk("drain", "end", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
